// File: rtl/bch_detect_pkg.sv
// Shared types and constants for the multi-lane BCH codeword checker.
package bch_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_RESULT  = 2'd3
  } bch_state_e;

  // Degree-112 generator (14 parity bytes); the x^112 term is implied.
  localparam logic [111:0] BCH_GENPOLY_DEFAULT =
    112'hB9E3_7C41_5A2D_0F86_C3E1_94D7_2B65;

  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/bch_remainder_lane.sv
// One byte lane: remainder register, byte-wide (8-step unrolled) division, zero detect.
module bch_remainder_lane
  import bch_detect_pkg::*;
#(
  parameter int                       ParityBytes = 14,
  parameter logic [8*ParityBytes-1:0] GenPoly     = BCH_GENPOLY_DEFAULT[8*ParityBytes-1:0]
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       shift_en_i,
  input  logic [7:0] byte_i,
  output logic       nonzero_o
);

  localparam int W = 8 * ParityBytes;

  logic [W-1:0] rem_q, rem_d;

  // MSB of the byte enters first, matching the encoder's bit order.
  function automatic logic [W-1:0] div_byte(input logic [W-1:0] r, input logic [7:0] d);
    logic [W-1:0] x;
    x = r;
    for (int b = 7; b >= 0; b--) begin
      x = {x[W-2:0], 1'b0} ^ ((x[W-1] ^ d[b]) ? GenPoly : '0);
    end
    return x;
  endfunction

  always_comb begin
    rem_d = rem_q;
    if (clear_i)         rem_d = '0;
    else if (shift_en_i) rem_d = div_byte(rem_q, byte_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rem_q <= '0;
    else        rem_q <= rem_d;
  end

  assign nonzero_o = |rem_q;

endmodule

// File: rtl/bch_error_detector_x.sv
// Multi-lane BCH codeword checker: FSM, beat counter, result handshake.
// Optional error-codeword counter enabled by defining BCH_ERROR_COUNT_EN.
module bch_error_detector_x
  import bch_detect_pkg::*;
#(
  parameter int                       Multi        = 2,
  parameter int                       MessageBytes = 512,
  parameter int                       ParityBytes  = 14,
  parameter logic [8*ParityBytes-1:0] GenPoly      = BCH_GENPOLY_DEFAULT[8*ParityBytes-1:0]
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic [8*Multi-1:0] iData,
  input  logic               iDataValid,
  output logic               oDataReady,
  output logic               oDataLast,
  output logic [Multi-1:0]   oErrorDetected,
  output logic               oResultValid,
  input  logic               iResultReady,
`ifdef BCH_ERROR_COUNT_EN
  input  logic               iCountClear,
  output logic [15:0]        oErrorCount,
`endif
  output logic               oBusy
);

  localparam int                TotalBeats = MessageBytes + ParityBytes;
  localparam int                CntW       = $clog2(TotalBeats);
  localparam logic [CntW-1:0]   LastBeat   = CntW'(TotalBeats - 1);

  bch_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Multi-1:0] flags_q, flags_d;
  logic [Multi-1:0] nonzero;
  logic             start, accept;

  assign start      = (state_q == ST_IDLE) && iEnable;
  assign oDataReady = (state_q == ST_RECEIVE);
  assign accept     = oDataReady && iDataValid;
  assign oDataLast  = oDataReady && (cnt_q == LastBeat);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    unique case (state_q)
      ST_IDLE: if (iEnable) begin
        state_d = ST_RECEIVE;
        cnt_d   = '0;
      end
      ST_RECEIVE: if (accept) begin
        cnt_d = cnt_q + CntW'(1);
        if (oDataLast) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        flags_d = nonzero;
        state_d = ST_RESULT;
      end
      ST_RESULT: if (iResultReady) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  for (genvar c = 0; c < Multi; c++) begin : g_lane
    bch_remainder_lane #(
      .ParityBytes (ParityBytes),
      .GenPoly     (GenPoly)
    ) u_lane (
      .clk_i      (iClock),
      .rst_i      (iReset),
      .clear_i    (start),
      .shift_en_i (accept),
      .byte_i     (iData[8*c +: 8]),
      .nonzero_o  (nonzero[c])
    );
  end

  assign oErrorDetected = flags_q;
  assign oResultValid   = (state_q == ST_RESULT);
  assign oBusy          = (state_q != ST_IDLE);

`ifdef BCH_ERROR_COUNT_EN
  logic [15:0] ecnt_q;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)                                   ecnt_q <= '0;
    else if (iCountClear)                         ecnt_q <= '0;
    else if (oResultValid && iResultReady && (|flags_q) && (ecnt_q != ERR_COUNT_MAX))
                                                  ecnt_q <= ecnt_q + 16'd1;
  end

  assign oErrorCount = ecnt_q;
`endif

endmodule

// File: doc/bch_error_detector_x.md
# bch_error_detector_x

Multi-lane BCH codeword checker for the read path of the flash channel. It complements the multi-lane BCH encoder on the write path. Each of `Multi` byte lanes receives a full systematic codeword: message bytes followed by parity bytes. The lane divides the codeword by the generator polynomial and reports per lane whether the remainder is non-zero, meaning errors are present. The flags let the controller skip the full decoder for clean pages.

## Interface
Parameters:
- `Multi`, 2, number of independent byte lanes.
- `MessageBytes`, 512, message bytes per lane per codeword.
- `ParityBytes`, 14, parity bytes per lane; generator degree is exactly `8*ParityBytes`.
- `GenPoly`, package default, `8*ParityBytes`-bit generator polynomial, leading x^deg term implied.

Ports:
- `iClock`, in, 1: single clock.
- `iReset`, in, 1: reset, asynchronous, active-high.
- `iEnable`, in, 1: start pulse, sampled only in IDLE.
- `iData`, in, `8*Multi`: lane c on bits `[8c+7:8c]`.
- `iDataValid`, in, 1: data beat valid.
- `oDataReady`, out, 1: detector accepts a beat.
- `oDataLast`, out, 1: current ready beat is the final codeword byte.
- `oErrorDetected`, out, `Multi`: per-lane remainder non-zero.
- `oResultValid`, out, 1: `oErrorDetected` is valid.
- `iResultReady`, in, 1: consumer takes the result.
- `oBusy`, out, 1: state is not IDLE.

## Operation
- FSM states:
  - IDLE → RECEIVE when `iEnable`. Entry clears all remainders and the beat counter.
  - RECEIVE → CHECK when the last beat is accepted.
  - CHECK → RESULT unconditionally.
  - RESULT → IDLE when `iResultReady`.
- A beat is accepted when `iDataValid && oDataReady`; `oDataReady` = (state==RECEIVE).
- Beat counter: width `clog2(MessageBytes+ParityBytes)`, +1 per accepted beat. `oDataLast` = `oDataReady && count==MessageBytes+ParityBytes-1` (combinational).
- Per-lane remainder update:
  - Remainder register is `8*ParityBytes` bits.
  - Each accepted byte is shifted in MSB first; 8 serial steps are unrolled into one cycle.
  - Each step: fb = rem[msb] ^ bit; rem = (rem<<1) ^ (fb ? GenPoly : 0).
  - The first beat holds the highest-order byte. Message and parity bytes are treated identically.
- CHECK registers `oErrorDetected[c] = |rem_c`.
- RESULT holds `oResultValid`=1 and the flags stable until `iResultReady`.
- `iEnable` outside IDLE is ignored, including in the same cycle as RESULT→IDLE.
- `iDataValid` outside RECEIVE is ignored; no beat is consumed.

## Timing
- Reset values:
  - state IDLE
  - `oDataReady`=0, `oDataLast`=0, `oResultValid`=0, `oBusy`=0
  - `oErrorDetected`=0, remainders=0, counter=0
- Start: `iEnable` at cycle T gives `oDataReady`=1 at T+1.
- Throughput: one beat per cycle; bubbles on `iDataValid` are allowed.
- Latency: last beat accepted at cycle N gives `oResultValid`=1 at N+2.
- Minimum turnaround: RESULT with `iResultReady` at cycle R gives IDLE at R+1; a new `iEnable` is honoured at R+1.
- Reset mid-codeword: asynchronous clear to reset values. A partial codeword is discarded and no result is produced.

## Configuration
- Macro `BCH_ERROR_COUNT_EN`.
- Defined:
  - Adds output `oErrorCount` [15:0]: number of completed codewords with any lane flagged.
  - Increments on the RESULT handshake and saturates at 16'hFFFF.
  - Resets to 0 asynchronously.
  - Extra input `iCountClear` (1 bit) zeroes the counter synchronously; clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is present.

## Structure
- Package `bch_detect_pkg`:
  - FSM state enum (IDLE, RECEIVE, CHECK, RESULT)
  - default `GenPoly` constant
  - counter saturation constant
- Sub-module `bch_remainder_lane`:
  - one per lane, generated `Multi` times
  - contains the remainder register, the 8-step unrolled division, and the zero-detect
  - ports: clear, shift-enable, byte in, non-zero flag
- The top level holds the FSM, beat counter, result handshake and optional error counter.

## Test plan
Bench parameters: Multi=2, MessageBytes=4, ParityBytes=1, GenPoly=8'h07.
- All-zero codeword (5 beats of 16'h0000) → `oErrorDetected`=2'b00 and `oResultValid` two cycles after the last beat. `oDataLast` is high on beat 5 only.
- Lane0 bytes 01,00,00,00,16; lane1 bytes 01,00,00,00,17 → `oErrorDetected`=2'b10.
- Same codeword with `iDataValid` low for 3 cycles between beats 2 and 3 → identical result. Exactly 5 beats are consumed.
- `iResultReady` held low for 10 cycles → flags and `oResultValid` stay stable. `iEnable` pulses during RECEIVE and RESULT are ignored.
- `iReset` asserted after beat 3 → all outputs go to 0 immediately. A following clean all-zero codeword reports 2'b00.
- With `BCH_ERROR_COUNT_EN` defined, 3 codewords with the lane1 error → `oErrorCount`=3. Then `iCountClear` together with a 4th erroneous handshake → 0.
